switch_alloc: RTL

SWITCH_ALLOC -- requirements
Module: switch_alloc

---
 rtl/switch_alloc_if.sv | 22 ++
 rtl/switch_alloc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/switch_alloc_if.sv
// Request/grant bundle between five input buffers, the allocator and the crossbar.
// The allocator takes the slave modport; the input/output port logic takes the master modport.
interface switch_alloc_if;
  logic [4:0]  req_valid;
  logic [14:0] req_dir;
  logic [4:0]  req_tail;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] xbar_sel;
  logic        dir_err;

  modport master (
    output req_valid, req_dir, req_tail, out_ready,
    input  grant, out_valid, xbar_sel, dir_err
  );

  modport slave (
    input  req_valid, req_dir, req_tail, out_ready,
    output grant, out_valid, xbar_sel, dir_err
  );
endinterface

// File: rtl/switch_alloc.sv
// Five-port wormhole switch allocator.
// Each output has a round-robin pointer and locks to one input from head flit to tail flit.
module switch_alloc (
  input logic           clk,
  input logic           rst_n,
  switch_alloc_if.slave io_bus
);
  localparam int unsigned NumPorts = 5;
  localparam logic [2:0]  NoOwner  = 3'b111;

  typedef enum logic {StIdle, StLocked} out_state_e;

  out_state_e          r_state     [NumPorts];
  out_state_e          w_state_nxt [NumPorts];
  logic [2:0]          r_owner     [NumPorts];
  logic [2:0]          w_owner_nxt [NumPorts];
  logic [2:0]          r_ptr       [NumPorts];
  logic [2:0]          w_ptr_nxt   [NumPorts];
  logic                r_dir_err;
  logic                w_dir_err_nxt;
  logic [NumPorts-1:0] w_owns;
  logic [NumPorts-1:0] w_cand      [NumPorts];
  logic [NumPorts-1:0] w_grant;
  logic [NumPorts-1:0] w_out_valid;
  logic [14:0]         w_xbar_sel;

  // An input already holding an output cannot compete for another one.
  always_comb begin : cand_logic
    w_owns = '0;
    for (int j = 0; j < NumPorts; j++) begin
      for (int i = 0; i < NumPorts; i++) begin
        if (r_state[j] == StLocked && r_owner[j] == 3'(i)) w_owns[i] = 1'b1;
      end
    end
    for (int j = 0; j < NumPorts; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < NumPorts; i++) begin
        w_cand[j][i] = io_bus.req_valid[i] && !w_owns[i] &&
                       (io_bus.req_dir[3*i +: 3] == 3'(j));
      end
    end
  end

  always_comb begin : next_logic
    logic        found;
    logic [2:0]  sel;
    logic [2:0]  sel_k;
    logic [2:0]  own;
    int unsigned idx;
    found         = 1'b0;
    sel           = NoOwner;
    sel_k         = NoOwner;
    own           = NoOwner;
    idx           = 0;
    w_grant       = '0;
    w_out_valid   = '0;
    w_xbar_sel    = '1;
    w_dir_err_nxt = r_dir_err;
    for (int j = 0; j < NumPorts; j++) begin
      w_state_nxt[j] = r_state[j];
      w_owner_nxt[j] = r_owner[j];
      w_ptr_nxt[j]   = r_ptr[j];
    end

    for (int j = 0; j < NumPorts; j++) begin
      own = r_owner[j];
      if (r_state[j] == StLocked) begin
        w_xbar_sel[3*j +: 3] = own;
        for (int i = 0; i < NumPorts; i++) begin
          if (own == 3'(i)) begin
            w_out_valid[j] = io_bus.req_valid[i];
            if (io_bus.req_valid[i] && io_bus.out_ready[j]) begin
              w_grant[i] = 1'b1;
              if (io_bus.req_tail[i]) begin
                w_state_nxt[j] = StIdle;
                w_owner_nxt[j] = NoOwner;
                w_ptr_nxt[j]   = own;
              end
            end
          end
        end
      end else begin
        found = 1'b0;
        sel   = NoOwner;
        for (int unsigned k = 1; k <= NumPorts; k++) begin
          idx   = (32'(r_ptr[j]) + k) % NumPorts;
          sel_k = idx[2:0];
          if (!found && w_cand[j][sel_k]) begin
            found = 1'b1;
            sel   = sel_k;
          end
        end
        if (found) begin
          w_state_nxt[j] = StLocked;
          w_owner_nxt[j] = sel;
        end
      end
    end

    for (int i = 0; i < NumPorts; i++) begin
      if (io_bus.req_valid[i] && io_bus.req_dir[3*i +: 3] > 3'd4) w_dir_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NumPorts; j++) begin
        r_state[j] <= StIdle;
        r_owner[j] <= NoOwner;
        r_ptr[j]   <= 3'd4;
      end
      r_dir_err <= 1'b0;
    end else begin
      for (int j = 0; j < NumPorts; j++) begin
        r_state[j] <= w_state_nxt[j];
        r_owner[j] <= w_owner_nxt[j];
        r_ptr[j]   <= w_ptr_nxt[j];
      end
      r_dir_err <= w_dir_err_nxt;
    end
  end

  assign io_bus.grant     = w_grant;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.xbar_sel  = w_xbar_sel;
  assign io_bus.dir_err   = r_dir_err;
endmodule
